// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory responder with programmable wait states
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr_en,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rd_data,
  output logic              resp_err,
  output logic              busy
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [3:0]          cnt;
  logic                lat_wr_en;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wr_data;

  logic                accept, do_access, acc_wr_en, acc_err;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         acc_wr_data;
  logic [IDX_W-1:0]    acc_idx;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign accept     = req_valid && req_ready;

  // With zero wait states the access happens on the accepting edge, so use the live inputs.
  always_comb begin
    acc_wr_en   = (state == IDLE) ? req_wr_en   : lat_wr_en;
    acc_addr    = (state == IDLE) ? req_addr    : lat_addr;
    acc_wr_data = (state == IDLE) ? req_wr_data : lat_wr_data;
    acc_idx     = acc_addr[IDX_W+1:2];
    acc_err     = (|acc_addr[1:0]) || (|acc_addr[ADDR_W-1:IDX_W+2]);
  end

  always_comb begin
    state_next = state;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          do_access  = (WAIT_CYCLES == 0);
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          do_access  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_wr_en    <= 1'b0;
      lat_addr     <= '0;
      lat_wr_data  <= '0;
      resp_rd_data <= '0;
      resp_err     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_wr_en   <= req_wr_en;
        lat_addr    <= req_addr;
        lat_wr_data <= req_wr_data;
        cnt         <= WAIT_INIT;
      end else if (state == WAIT && cnt > 4'd1) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        resp_err     <= acc_err;
        resp_rd_data <= (acc_err || acc_wr_en) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Contents survive reset; only a store completing outside reset is committed.
  always_ff @(posedge clk) begin
    if (!reset && do_access && acc_wr_en && !acc_err)
      mem[acc_idx] <= acc_wr_data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_wr_en, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr [2];
  logic [31:0] req_wr_data [2];
  logic [31:0] resp_rd_data [2];

  logic [31:0] mm [2][256];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr_en(req_wr_en[0]),
    .req_addr(req_addr[0]), .req_wr_data(req_wr_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rd_data(resp_rd_data[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr_en(req_wr_en[1]),
    .req_addr(req_addr[1]), .req_wr_data(req_wr_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rd_data(resp_rd_data[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  // One complete request/response; the model decides latency, data and error from the address rules.
  task automatic txn(input int w, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input int hold, input bit scramble);
    int          lat;
    int          wc;
    bit          exp_e;
    logic [31:0] exp_d;
    wc    = (w == 0) ? 2 : 0;
    exp_e = (addr[1:0] != 2'b00) || ((addr >> 2) >= 256);
    exp_d = (exp_e || wr) ? 32'd0 : mm[w][addr[9:2]];
    if (!exp_e && wr) mm[w][addr[9:2]] = data;
    @(negedge clk);
    n_vec++;
    if (req_ready[w] !== 1'b1) begin n_bad++; $display("FAIL ready_before_req[%0d]: got %b expected 1", w, req_ready[w]); end
    req_valid[w]   = 1'b1;
    req_wr_en[w]   = wr;
    req_addr[w]    = addr;
    req_wr_data[w] = data;
    resp_ready[w]  = (hold == 0);
    @(posedge clk);
    lat = 1;
    #1;
    req_valid[w] = 1'b0;
    if (scramble) begin
      req_addr[w]    = $urandom;
      req_wr_data[w] = $urandom;
      req_wr_en[w]   = ~wr;
    end
    while (resp_valid[w] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    n_vec++;
    if (lat != wc + 1) begin n_bad++; $display("FAIL latency[%0d]: got %0d expected %0d", w, lat, wc + 1); end
    n_vec++;
    if (resp_rd_data[w] !== exp_d) begin n_bad++; $display("FAIL rd_data[%0d] addr %h: got %h expected %h", w, addr, resp_rd_data[w], exp_d); end
    n_vec++;
    if (resp_err[w] !== exp_e) begin n_bad++; $display("FAIL err[%0d] addr %h: got %b expected %b", w, addr, resp_err[w], exp_e); end
    n_vec++;
    if (busy[w] !== 1'b1 || req_ready[w] !== 1'b0) begin n_bad++; $display("FAIL busy_in_resp[%0d]: got busy %b ready %b expected 1 0", w, busy[w], req_ready[w]); end
    for (int i = 0; i < hold; i++) begin
      req_valid[w] = 1'b1;
      req_addr[w]  = $urandom;
      @(posedge clk);
      #1;
      n_vec++;
      if (resp_valid[w] !== 1'b1 || req_ready[w] !== 1'b0 || resp_rd_data[w] !== exp_d || resp_err[w] !== exp_e) begin
        n_bad++;
        $display("FAIL hold[%0d] cyc %0d: got v %b rdy %b d %h e %b expected 1 0 %h %b",
                 w, i, resp_valid[w], req_ready[w], resp_rd_data[w], resp_err[w], exp_d, exp_e);
      end
    end
    req_valid[w]  = 1'b0;
    resp_ready[w] = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (resp_valid[w] !== 1'b0 || req_ready[w] !== 1'b1 || busy[w] !== 1'b0) begin
      n_bad++;
      $display("FAIL retire[%0d]: got v %b rdy %b busy %b expected 0 1 0", w, resp_valid[w], req_ready[w], busy[w]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (req_ready[w] !== 1'b1 || resp_valid[w] !== 1'b0 || busy[w] !== 1'b0 ||
          resp_rd_data[w] !== 32'd0 || resp_err[w] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got rdy %b v %b busy %b d %h e %b expected 1 0 0 0 0",
                 w, req_ready[w], resp_valid[w], busy[w], resp_rd_data[w], resp_err[w]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
  endtask

  task automatic test_errors();
    txn(0, 1'b1, 32'h100, 32'hCAFEF00D, 0, 1'b0);
    txn(0, 1'b0, 32'h12, 32'h0, 0, 1'b0);
    txn(0, 1'b0, 32'h400, 32'h0, 0, 1'b0);
    txn(0, 1'b1, 32'h402, 32'h11111111, 0, 1'b0);
    txn(0, 1'b1, 32'h3FC, 32'h22222222, 0, 1'b0);
    txn(0, 1'b0, 32'h100, 32'h0, 0, 1'b0);
    txn(0, 1'b0, 32'h3FC, 32'h0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b0);
  endtask

  task automatic test_latch();
    txn(0, 1'b1, 32'h40, 32'hA0A0A0A0, 1, 1'b1);
    txn(0, 1'b0, 32'h40, 32'h0, 0, 1'b1);
  endtask

  task automatic test_zero_wait();
    int acc;
    txn(1, 1'b1, 32'h4, 32'h000000A5, 0, 1'b0);
    txn(1, 1'b0, 32'h4, 32'h0, 0, 1'b0);
    acc = 0;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_wr_en[1] = 1'b0;
    req_addr[1]  = 32'h4;
    resp_ready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready[1] === 1'b1) acc++;
      if (resp_valid[1] === 1'b1) begin
        n_vec++;
        if (resp_rd_data[1] !== 32'hA5) begin n_bad++; $display("FAIL b2b_data: got %h expected 000000a5", resp_rd_data[1]); end
      end
      if (i == 9) req_valid[1] = 1'b0;
    end
    n_vec++;
    if (acc != 5) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 5", acc); end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] prior;
    int          guard;
    prior = $urandom;
    txn(0, 1'b1, 32'h20, prior, 0, 1'b0);
    // Reset one cycle after accepting: the store must be discarded.
    @(negedge clk);
    req_valid[0] = 1'b1; req_wr_en[0] = 1'b1; req_addr[0] = 32'h20; req_wr_data[0] = 32'h12345678;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
        resp_rd_data[0] !== 32'd0 || resp_err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_wait: got rdy %b v %b busy %b d %h e %b expected 1 0 0 0 0",
               req_ready[0], resp_valid[0], busy[0], resp_rd_data[0], resp_err[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    // Reset while the response is pending: the committed store stays.
    @(negedge clk);
    req_valid[0] = 1'b1; req_wr_en[0] = 1'b1; req_addr[0] = 32'h24; req_wr_data[0] = 32'h5A5A1234;
    resp_ready[0] = 1'b0;
    mm[0][9] = 32'h5A5A1234;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    guard = 0;
    while (resp_valid[0] !== 1'b1 && guard < 40) begin @(posedge clk); guard++; #1; end
    n_vec++;
    if (resp_valid[0] !== 1'b1) begin n_bad++; $display("FAIL resp_timeout: got 0 expected 1"); end
    @(negedge clk);
    reset = 1'b1;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_resp: got v %b rdy %b expected 0 1", resp_valid[0], req_ready[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    txn(0, 1'b0, 32'h24, 32'h0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 7) a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      else a = 32'($urandom_range(0, 2047));
      txn(n % 2, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 256; i++) mm[w][i] = 32'd0;
      req_addr[w]    = 32'd0;
      req_wr_data[w] = 32'd0;
    end
    req_valid  = 2'b00;
    req_wr_en  = 2'b00;
    resp_ready = 2'b00;
    reset      = 1'b1;
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_latch();
    test_zero_wait();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
